regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with per-register busy scoreboard, for the pipelined/dual-issue core. It provides NRP combinational read ports and NWP write ports with write-to-read bypass. A reservation port marks destination registers busy at issue so decode can detect RAW hazards. It sits between decode/issue (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32: data width.
- NREG, 32: register count, power of two ≥ 2; AW = $clog2(NREG).
- NRP, 2: read ports.
- NWP, 2: write ports.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rp_addr  in  NRP×AW  read addresses.
- rp_data  out  NRP×XLEN  read data (combinational).
- rp_busy  out  NRP  addressed register busy and not written this cycle.
- wp_en  in  NWP  write enables.
- wp_addr  in  NWP×AW  write addresses.
- wp_data  in  NWP×XLEN  write data.
- rsv_en  in  1  reserve rsv_addr (mark busy).
- rsv_addr  in  AW  register to reserve.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_cnt  out  AW+1  number of busy registers.

## Operation
- Register 0 reads 0 and is never busy. Writes and reservations to address 0 are ignored.
- Write: for each p with wp_en[p] and wp_addr[p]≠0, regs[wp_addr[p]] ← wp_data[p] at the edge. If two ports target the same address, the higher port index wins.
- Read: rp_data[i] = the winning same-cycle write data if an enabled write targets rp_addr[i]≠0 (write-first bypass); otherwise regs[rp_addr[i]]; 0 for address 0.
- Busy set: rsv_en with rsv_addr≠0 sets busy[rsv_addr].
- Busy clear: any enabled write to address a≠0 clears busy[a].
- Same-cycle reserve and write to the same address: the reservation wins and busy stays/becomes 1. The write data is still stored.
- flush clears every busy bit and overrides a same-cycle reservation. Writes in that cycle still update data.
- rp_busy[i] = busy[rp_addr[i]] & ~(enabled write to rp_addr[i] this cycle). It is 0 for address 0.
- busy_cnt: registered count of set busy bits, updated each edge to the popcount of the next busy vector. Range is 0..NREG−1.
- reset clears all registers to 0, all busy bits, and busy_cnt. reset has priority over write, reserve and flush.

## Timing
- Read and bypass paths are combinational, with zero latency.
- Writes are visible in regs the cycle after the edge, and in the same cycle via bypass.
- A reservation affects rp_busy from the next cycle.
- busy_cnt lags the busy vector by 0 cycles: it is registered alongside the busy vector.
- Reset values: rp_data = 0 for all addresses, rp_busy = 0, busy_cnt = 0, from the cycle after reset is sampled high.
- Reset asserted mid-stream discards all writes and reservations in that cycle.

## Structure
- Package regfile_pkg holds NREG_DEFAULT, XLEN_DEFAULT, the typedef for the register-address type, and a popcount function.
- One sub-module, regfile_wr_arb, resolves the NWP write ports per address (winner select and hit vector). It is shared by the storage write, the bypass mux and the busy-clear logic.
- Storage is a flop array (no SRAM), because resettable contents are required.

## Test plan
- Reset then read all addresses on both ports: expect 0, rp_busy=0, busy_cnt=0.
- Write x5=0xDEADBEEF on port 0 while reading x5 on port 1 in the same cycle: bypass returns 0xDEADBEEF. Also write x0=0x1234: a read of x0 returns 0.
- Both write ports target x7 (port0=0x11, port1=0x22): the next-cycle read of x7 returns 0x22.
- Reserve x3, x4, x9 on consecutive cycles: busy_cnt reaches 3 and rp_busy is set for x3. Then write x3: rp_busy is 0 in that same cycle and busy_cnt is 2 next cycle.
- Reserve x6 and write x6 in the same cycle: busy stays 1 and data is updated. Then flush plus reserve x8 in the same cycle: busy_cnt is 0.
- Fill registers with data, reserve x10, then assert reset for one cycle with concurrent writes: all reads return 0 and busy_cnt is 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, the register-address type and a popcount helper for the
// scoreboarded register file.
package regfile_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int XLEN_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    // Widest busy vector the popcount helper accepts.
    localparam int POPCNT_MAX   = 64;

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    function automatic logic [6:0] popcount(input logic [POPCNT_MAX-1:0] vec);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < POPCNT_MAX; i++) begin
            cnt = cnt + 7'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-address write-port resolution: which registers are written this cycle
// and, for each, the data of the highest-indexed enabled port that targets it.
module regfile_wr_arb #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int NWP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [NWP-1:0]       wp_en_i,
    input  logic [NWP*AW-1:0]    wp_addr_i,
    input  logic [NWP*XLEN-1:0]  wp_data_i,
    output logic [NREG-1:0]      hit_o,
    output logic [NREG*XLEN-1:0] win_data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_addr
            logic            hit_a;
            logic [XLEN-1:0] data_a;

            if (gi == 0) begin : g_zero
                // x0 is hardwired: never hit, never carries data.
                assign hit_a  = 1'b0;
                assign data_a = '0;
            end else begin : g_reg
                // Ascending scan so the highest matching port is assigned last.
                always_comb begin
                    hit_a  = 1'b0;
                    data_a = '0;
                    for (int p = 0; p < NWP; p++) begin
                        if (wp_en_i[p] && (wp_addr_i[p*AW +: AW] == AW'(gi))) begin
                            hit_a  = 1'b1;
                            data_a = wp_data_i[p*XLEN +: XLEN];
                        end
                    end
                end
            end

            assign hit_o[gi]                  = hit_a;
            assign win_data_o[gi*XLEN +: XLEN] = data_a;
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-first bypass and a per-register
// busy scoreboard used by decode to detect RAW hazards.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRP*AW-1:0]    rp_addr,
    output logic [NRP*XLEN-1:0]  rp_data,
    output logic [NRP-1:0]       rp_busy,
    input  logic [NWP-1:0]       wp_en,
    input  logic [NWP*AW-1:0]    wp_addr,
    input  logic [NWP*XLEN-1:0]  wp_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic [AW:0]          busy_cnt
);

    localparam int CW = AW + 1;

    logic [NREG-1:0]      wr_hit;
    logic [NREG*XLEN-1:0] wr_data;

    regfile_wr_arb #(
        .NREG (NREG),
        .XLEN (XLEN),
        .NWP  (NWP),
        .AW   (AW)
    ) u_wr_arb (
        .wp_en_i    (wp_en),
        .wp_addr_i  (wp_addr),
        .wp_data_i  (wp_data),
        .hit_o      (wr_hit),
        .win_data_o (wr_data)
    );

    // Storage is flops so the whole file clears on reset.
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        for (int a = 0; a < NREG; a++) begin
            regs_d[a] = regs_q[a];
            if (wr_hit[a]) begin
                regs_d[a] = wr_data[a*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NREG; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NREG; a++) begin
                regs_q[a] <= regs_d[a];
            end
        end
    end

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] rsv_mask;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    always_comb begin
        rsv_mask = '0;
        if (rsv_en && (rsv_addr != '0)) begin
            rsv_mask[rsv_addr] = 1'b1;
        end
    end

    // Reservation is OR-ed in after the write clear so it wins; flush beats both.
    always_comb begin
        busy_d = (busy_q & ~wr_hit) | rsv_mask;
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0]  = 1'b0;
        busy_cnt_d = CW'(popcount(POPCNT_MAX'(busy_d)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0]   rd_addr;
            logic [XLEN-1:0] rd_data;
            logic            rd_busy;

            assign rd_addr = rp_addr[gi*AW +: AW];

            always_comb begin
                rd_data = regs_q[rd_addr];
                rd_busy = busy_q[rd_addr] & ~wr_hit[rd_addr];
                if (wr_hit[rd_addr]) begin
                    rd_data = wr_data[rd_addr*XLEN +: XLEN];
                end
                if (rd_addr == '0) begin
                    rd_data = '0;
                    rd_busy = 1'b0;
                end
            end

            assign rp_data[gi*XLEN +: XLEN] = rd_data;
            assign rp_busy[gi]              = rd_busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised stimulus for regfile_sb, checked every cycle against
// an array-based model of the register file and scoreboard.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRP*AW-1:0]   rp_addr;
    logic [NRP*XLEN-1:0] rp_data;
    logic [NRP-1:0]      rp_busy;
    logic [NWP-1:0]      wp_en;
    logic [NWP*AW-1:0]   wp_addr;
    logic [NWP*XLEN-1:0] wp_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRP  (NRP),
        .NWP  (NWP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rp_addr  (rp_addr),
        .rp_data  (rp_data),
        .rp_busy  (rp_busy),
        .wp_en    (wp_en),
        .wp_addr  (wp_addr),
        .wp_data  (wp_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    // ---------------- model ----------------
    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    bit          m_valid = 1'b0;

    function automatic bit m_written(input int a);
        bit w = 1'b0;
        for (int p = 0; p < NWP; p++) begin
            if (wp_en[p] && int'(wp_addr[p*AW +: AW]) == a) w = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] d;
        if (a == 0) return 32'h0;
        d = m_regs[a];
        for (int p = 0; p < NWP; p++) begin
            if (wp_en[p] && int'(wp_addr[p*AW +: AW]) == a) d = wp_data[p*XLEN +: XLEN];
        end
        return d;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int a = 0; a < NREG; a++) c += int'(m_busy[a]);
        return c;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NREG; a++) begin
                m_regs[a] <= 32'h0;
                m_busy[a] <= 1'b0;
            end
            m_valid <= 1'b1;
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (wp_en[p] && wp_addr[p*AW +: AW] != 0) begin
                    m_regs[wp_addr[p*AW +: AW]] <= wp_data[p*XLEN +: XLEN];
                    m_busy[wp_addr[p*AW +: AW]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
            if (flush) begin
                for (int a = 0; a < NREG; a++) m_busy[a] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && !reset) begin
            for (int i = 0; i < NRP; i++) begin
                int a;
                a = int'(rp_addr[i*AW +: AW]);
                check($sformatf("model rp_data[%0d] x%0d", i, a),
                      rp_data[i*XLEN +: XLEN], m_read(a));
                check($sformatf("model rp_busy[%0d] x%0d", i, a), 32'(rp_busy[i]),
                      32'((a != 0) && m_busy[a] && !m_written(a)));
            end
            check("model busy_cnt", 32'(busy_cnt), 32'(m_count()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wp_en    = '0;
        wp_addr  = '0;
        wp_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rp_addr[0 +: AW]  = AW'(a0);
        rp_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wp_en[p]                = 1'b1;
        wp_addr[p*AW +: AW]     = AW'(a);
        wp_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = AW'(a);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reg_addr_t ra;
        reset = 1'b1;
        idle();
        set_rd(0, 0);
        step();
        step();
        reset = 1'b0;

        // After reset every address reads zero and nothing is busy.
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG - 1 - a);
            @(negedge clk);
            check("reset rp_data0", rp_data[31:0], 32'h0);
            check("reset rp_data1", rp_data[63:32], 32'h0);
            check("reset rp_busy", 32'(rp_busy), 32'h0);
            step();
        end
        check("reset busy_cnt", 32'(busy_cnt), 32'h0);

        // Bypass of x5, write to x0 ignored, reservation of x0 ignored.
        idle();
        wr(0, 5, 32'hDEADBEEF);
        wr(1, 0, 32'h0000_1234);
        rsv(0);
        set_rd(0, 5);
        @(negedge clk);
        check("bypass x0", rp_data[31:0], 32'h0);
        check("bypass x5", rp_data[63:32], 32'hDEADBEEF);
        step();
        idle();
        set_rd(5, 0);
        @(negedge clk);
        check("stored x5", rp_data[31:0], 32'hDEADBEEF);
        check("stored x0", rp_data[63:32], 32'h0);
        check("rsv x0 ignored", 32'(busy_cnt), 32'h0);

        // Both ports write x7: port 1 wins in bypass and storage.
        step();
        idle();
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        set_rd(7, 7);
        @(negedge clk);
        check("x7 bypass winner", rp_data[31:0], 32'h22);
        step();
        idle();
        set_rd(7, 0);
        @(negedge clk);
        check("x7 stored winner", rp_data[31:0], 32'h22);

        // Reserve x3, x4, x9; then a write to x3 clears it.
        step(); idle(); rsv(3);
        step(); idle(); rsv(4);
        step(); idle(); rsv(9);
        step(); idle(); set_rd(3, 9);
        @(negedge clk);
        check("rsv busy_cnt 3", 32'(busy_cnt), 32'd3);
        check("rsv x3 busy", 32'(rp_busy[0]), 32'd1);
        check("rsv x9 busy", 32'(rp_busy[1]), 32'd1);
        step(); idle();
        wr(0, 3, 32'h33);
        set_rd(3, 9);
        @(negedge clk);
        check("x3 write hides busy", 32'(rp_busy[0]), 32'd0);
        check("x3 write bypass", rp_data[31:0], 32'h33);
        step(); idle(); set_rd(3, 4);
        @(negedge clk);
        check("busy_cnt after clear", 32'(busy_cnt), 32'd2);
        check("x3 cleared", 32'(rp_busy[0]), 32'd0);
        check("x4 still busy", 32'(rp_busy[1]), 32'd1);

        // Reserve and write x6 together: reservation wins, data stored.
        step(); idle();
        rsv(6);
        wr(1, 6, 32'h66);
        set_rd(6, 0);
        @(negedge clk);
        check("x6 same-cycle data", rp_data[31:0], 32'h66);
        step(); idle(); set_rd(6, 0);
        @(negedge clk);
        check("x6 busy kept", 32'(rp_busy[0]), 32'd1);
        check("x6 data stored", rp_data[31:0], 32'h66);
        check("busy_cnt 3 again", 32'(busy_cnt), 32'd3);

        // Flush overrides a same-cycle reservation of x8.
        step(); idle();
        flush = 1'b1;
        rsv(8);
        set_rd(8, 4);
        @(negedge clk);
        check("pre-flush x4 busy", 32'(rp_busy[1]), 32'd1);
        step(); idle(); set_rd(8, 4);
        @(negedge clk);
        check("flush busy_cnt", 32'(busy_cnt), 32'd0);
        check("flush x8 not busy", 32'(rp_busy[0]), 32'd0);
        check("flush x4 not busy", 32'(rp_busy[1]), 32'd0);

        // Fill, reserve x10, then reset with concurrent writes and reservation.
        for (int a = 0; a < 16; a++) begin
            step(); idle();
            wr(0, a, 32'hA000_0000 + 32'(a));
            wr(1, a + 16, 32'hB000_0000 + 32'(a + 16));
        end
        step(); idle(); rsv(10);
        step(); idle(); set_rd(10, 17);
        @(negedge clk);
        check("x10 busy", 32'(rp_busy[0]), 32'd1);
        check("x17 filled", rp_data[63:32], 32'hB000_0011);
        check("fill busy_cnt", 32'(busy_cnt), 32'd1);
        step(); idle();
        reset = 1'b1;
        wr(0, 12, 32'h0000_FFFF);
        rsv(13);
        step();
        reset = 1'b0;
        idle();
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG - 1 - a);
            @(negedge clk);
            check("post-reset rp_data0", rp_data[31:0], 32'h0);
            check("post-reset rp_busy", 32'(rp_busy), 32'h0);
            step();
        end
        check("post-reset busy_cnt", 32'(busy_cnt), 32'h0);

        // Mixed traffic on a narrow address range to force collisions.
        for (int n = 0; n < 300; n++) begin
            idle();
            for (int p = 0; p < NWP; p++) begin
                if ($urandom_range(0, 1) == 1) wr(p, int'($urandom_range(0, 7)), $urandom());
            end
            if ($urandom_range(0, 2) != 0) begin
                ra = reg_addr_t'($urandom_range(0, 9));
                rsv(int'(ra));
            end
            flush = ($urandom_range(0, 19) == 0);
            set_rd(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
